// File: rtl/imem_responder_pkg.sv
// Shared types for the instruction-fetch memory responder.
// cpu_types_pkg: word and RAM handshake types.
// cache_pkg: responder FSM states and the word returned on a forced completion.
package cpu_types_pkg;
    typedef logic [31:0] word_t;
    typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
endpackage

package cache_pkg;
    import cpu_types_pkg::*;
    typedef enum logic {IM_IDLE, IM_REQ} imresp_state_t;
    localparam word_t BADWORD_DEFAULT = 32'hBAD1BAD1;
endpackage

// File: rtl/imem_responder_rr_arbiter.sv
// Combinational round-robin picker: returns the first set request bit at or
// after ptr, wrapping around CPUS. The pointer itself lives in the caller.
module rr_arbiter #(
    parameter int CPUS = 2,
    parameter int IW   = 1
)(
    input  logic [CPUS-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [IW-1:0]   grant,
    output logic            valid
);

    logic [CPUS-1:0] rot;
    logic [IW:0]     idx;

    // rotate so that bit 0 is the requester at ptr, then take the lowest set bit
    always_comb begin
        rot   = CPUS'({req, req} >> ptr);
        grant = '0;
        valid = 1'b0;
        idx   = '0;
        for (int i = 0; i < CPUS; i++) begin
            if (!valid && rot[i]) begin
                valid = 1'b1;
                idx   = {1'b0, ptr} + (IW+1)'(i);
                if (idx >= (IW+1)'(CPUS)) begin
                    idx = idx - (IW+1)'(CPUS);
                end
                grant = idx[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/imem_responder.sv
// Instruction-fetch memory responder: arbitrates icache reads round-robin,
// issues one RAM read at a time and completes with a one-cycle iwait-low pulse.
// Optional build macro RESP_TIMEOUT_EN adds a RAM wait limit that forces a
// completion carrying BADWORD.
//
// state   | meaning
// IM_IDLE | no RAM access; pick the next requester (also the post-completion bubble)
// IM_REQ  | RAM read for the granted CPU in flight; complete on ACCESS
module imem_responder
    import cpu_types_pkg::*;
    import cache_pkg::*;
#(
    parameter int CPUS = 2
`ifdef RESP_TIMEOUT_EN
    ,
    parameter int    TIMEOUT = 64,
    parameter word_t BADWORD = BADWORD_DEFAULT
`endif
)(
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic [CPUS-1:0]       iREN,
    input  logic [CPUS-1:0][31:0] iaddr,
    output logic [CPUS-1:0]       iwait,
    output logic [CPUS-1:0][31:0] iload,
    output logic                  ramREN,
    output logic [31:0]           ramaddr,
    input  logic [31:0]           ramload,
    input  ramstate_t             ramstate
);

    localparam int IW = (CPUS > 1) ? $clog2(CPUS) : 1;

    imresp_state_t state_q, state_d;
    logic [IW-1:0] grant_q, grant_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IW-1:0] next_ptr;
    logic [IW-1:0] arb_grant;
    logic          arb_valid;
    word_t         sel_addr;
    logic          unused_addr_lsbs;

`ifdef RESP_TIMEOUT_EN
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          cnt_expired;
    assign cnt_expired = (cnt_q == CW'(TIMEOUT-1));
`endif

    rr_arbiter #(.CPUS(CPUS), .IW(IW)) u_arb (
        .req   (iREN),
        .ptr   (rr_ptr_q),
        .grant (arb_grant),
        .valid (arb_valid)
    );

    assign sel_addr         = iaddr[grant_q];
    assign unused_addr_lsbs = ^sel_addr[1:0];
    assign next_ptr         = (grant_q == IW'(CPUS-1)) ? '0 : grant_q + 1'b1;

    // state, grant, pointer and wait-counter registers
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q  <= IM_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
`ifdef RESP_TIMEOUT_EN
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
`ifdef RESP_TIMEOUT_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

    // next state and outputs; outputs stay quiet while nRST is low
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        iwait    = '1;
        iload    = '0;
        ramREN   = 1'b0;
        ramaddr  = '0;
`ifdef RESP_TIMEOUT_EN
        cnt_d    = '0;
`endif
        if (nRST) begin
            case (state_q)
                IM_IDLE: begin
                    if (arb_valid) begin
                        grant_d = arb_grant;
                        state_d = IM_REQ;
                    end
                end
                IM_REQ: begin
                    ramREN  = 1'b1;
                    ramaddr = {sel_addr[31:2], 2'b00};
                    if (!iREN[grant_q]) begin
                        // requester gave up: drop the read, pointer untouched
                        state_d = IM_IDLE;
                    end else if (ramstate == ACCESS) begin
                        iwait[grant_q] = 1'b0;
                        iload[grant_q] = ramload;
                        rr_ptr_d       = next_ptr;
                        state_d        = IM_IDLE;
`ifdef RESP_TIMEOUT_EN
                    end else if (cnt_expired) begin
                        iwait[grant_q] = 1'b0;
                        iload[grant_q] = BADWORD;
                        rr_ptr_d       = next_ptr;
                        state_d        = IM_IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
`endif
                    end
                end
                default: state_d = IM_IDLE;
            endcase
        end
    end

endmodule
